cla16_pipe: RTL and testbench

Two-stage pipelined 16-bit carry-lookahead adder built around the `gp4` 4-bit generate/propagate lookahead unit, and its direct consumer. Stage 1 forms bit-level and 4-bit group generate/propagate terms. Stage 2 resolves group carries through a second-level `gp4`, then forms the sum. Operands move in and results move out over valid/ready handshakes with full backpressure, so the block can be placed in the datapath between elastic producers and consumers.

---
 rtl/cla16_pipe.sv | 160 ++++++++++++++++
 tb/tb_cla16_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla16_pipe.sv
// Two-stage pipelined 16-bit carry-lookahead adder with elastic valid/ready
// ports. Stage 1 registers bit and group g/p terms; stage 2 resolves carries.

module gp4 (
  input  logic [3:0] gin,
  input  logic [3:0] pin,
  input  logic       cin,
  output logic       gout,
  output logic       pout,
  output logic [3:0] cout
);
  // cout[k] is the carry out of bit k, i.e. the carry into bit k+1.
  assign cout[0] = gin[0] | (pin[0] & cin);
  assign cout[1] = gin[1] | (pin[1] & gin[0]) | (pin[1] & pin[0] & cin);
  assign cout[2] = gin[2] | (pin[2] & gin[1]) | (pin[2] & pin[1] & gin[0])
                 | (pin[2] & pin[1] & pin[0] & cin);
  assign cout[3] = gout | (pout & cin);
  assign gout    = gin[3] | (pin[3] & gin[2]) | (pin[3] & pin[2] & gin[1])
                 | (pin[3] & pin[2] & pin[1] & gin[0]);
  assign pout    = &pin;
endmodule

module cla16_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        cout,
  output logic        gout,
  output logic        pout
);
  // Handshake: a beat transfers on any edge where valid & ready are both high.
  // ready never depends on the same port's valid, so no combinational loop.

  logic        s1_valid;
  logic [15:0] s1_p, s1_g;
  logic [3:0]  s1_grp_g, s1_grp_p;
  logic        s1_cin;

  logic        s2_ready, advance, load;

  logic [15:0] bit_g, bit_p;
  logic [3:0]  grp_g, grp_p;
  logic [3:0]  s1_grp_cout [4];

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  // Stage 1 groups only need G/P, so their carry-in is tied low.
  for (genvar j = 0; j < 4; j++) begin : g_s1_grp
    gp4 u_gp4 (
      .gin  (bit_g[4*j +: 4]),
      .pin  (bit_p[4*j +: 4]),
      .cin  (1'b0),
      .gout (grp_g[j]),
      .pout (grp_p[j]),
      .cout (s1_grp_cout[j])
    );
  end

  logic       l2_gout, l2_pout;
  logic [3:0] l2_cout;
  logic [3:0] grp_cin;

  gp4 u_level2 (
    .gin  (s1_grp_g),
    .pin  (s1_grp_p),
    .cin  (s1_cin),
    .gout (l2_gout),
    .pout (l2_pout),
    .cout (l2_cout)
  );

  assign grp_cin = {l2_cout[2:0], s1_cin};

  logic [3:0] s2_grp_cout [4];
  logic [3:0] s2_grp_g_unused, s2_grp_p_unused;

  // Group units re-evaluated with their real carry-in give intra-group carries.
  for (genvar j = 0; j < 4; j++) begin : g_s2_grp
    gp4 u_gp4 (
      .gin  (s1_g[4*j +: 4]),
      .pin  (s1_p[4*j +: 4]),
      .cin  (grp_cin[j]),
      .gout (s2_grp_g_unused[j]),
      .pout (s2_grp_p_unused[j]),
      .cout (s2_grp_cout[j])
    );
  end

  logic [15:0] carry_into;
  logic [15:0] sum_next;
  logic        cout_next;

  always_comb begin
    carry_into = '0;
    for (int j = 0; j < 4; j++) begin
      carry_into[4*j]   = grp_cin[j];
      carry_into[4*j+1] = s2_grp_cout[j][0];
      carry_into[4*j+2] = s2_grp_cout[j][1];
      carry_into[4*j+3] = s2_grp_cout[j][2];
    end
    sum_next  = s1_p ^ carry_into;
    cout_next = l2_gout | (l2_pout & s1_cin);
  end

  logic unused_bits;
  assign unused_bits = ^{s1_grp_cout[0], s1_grp_cout[1], s1_grp_cout[2],
                         s1_grp_cout[3], s2_grp_cout[0][3], s2_grp_cout[1][3],
                         s2_grp_cout[2][3], s2_grp_cout[3][3], l2_cout[3],
                         s2_grp_g_unused, s2_grp_p_unused};

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign advance  = s1_valid && s2_ready;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_p      <= '0;
      s1_g      <= '0;
      s1_grp_g  <= '0;
      s1_grp_p  <= '0;
      s1_cin    <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      gout      <= 1'b0;
      pout      <= 1'b0;
    end else begin
      if (load) begin
        s1_p     <= bit_p;
        s1_g     <= bit_g;
        s1_grp_g <= grp_g;
        s1_grp_p <= grp_p;
        s1_cin   <= cin;
        s1_valid <= 1'b1;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end

      if (advance) begin
        sum       <= sum_next;
        cout      <= cout_next;
        gout      <= l2_gout;
        pout      <= l2_pout;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cla16_pipe.sv
// Bench for cla16_pipe: directed corner cases plus randomized elastic traffic
// scored against an arithmetic reference model.

module tb_cla16_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout, gout, pout;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected result packed as {gout, pout, cout, sum}.
  logic [18:0] exp_q[$];

  cla16_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .gout      (gout),
    .pout      (pout)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    logic [16:0] full, no_cin;
    full   = {1'b0, x} + {1'b0, y} + {16'd0, c};
    no_cin = {1'b0, x} + {1'b0, y};
    return {no_cin[16], (x ^ y) == 16'hFFFF, full};
  endfunction

  // Drive one cycle at the falling edge, then report what the handshakes did
  // at the following rising edge and the output beat visible during it.
  task automatic step(input logic iv, input logic [15:0] ta, input logic [15:0] tb_v,
                      input logic tc, input logic ordy,
                      output logic acc, output logic fired, output logic [18:0] obs);
    @(negedge clk);
    in_valid  = iv;
    a         = ta;
    b         = tb_v;
    cin       = tc;
    out_ready = ordy;
    #1;
    acc   = iv && in_ready;
    fired = out_valid && out_ready;
    obs   = {gout, pout, cout, sum};
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic acc, fired;
    logic [18:0] obs;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, sum, cout, gout, pout, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state: got ov=%b sum=%h cout=%b g=%b p=%b ir=%b, want ov=0 sum=0000 cout=0 g=0 p=0 ir=1",
               out_valid, sum, cout, gout, pout, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, fired, obs);
      tests_run++;
      if (fired !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_no_beat: cycle %0d got out_valid=%b, want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_single(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                             input logic tc, input logic [18:0] want);
    logic acc, fired;
    logic [18:0] obs;
    step(1'b1, ta, tb_v, tc, 1'b1, acc, fired, obs);
    tests_run++;
    if (acc !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_accept: got in_ready=%b, want 1", name, acc);
    end
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, fired, obs);
    tests_run++;
    if (fired !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_latency_early: got out_valid=%b one cycle after accept, want 0", name, fired);
    end
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, fired, obs);
    tests_run++;
    if ({fired, obs} !== {1'b1, want}) begin
      tests_failed++;
      $display("FAIL %s_result: got valid=%b {g,p,cout,sum}=%h, want valid=1 %h", name, fired, obs, want);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, fired;
    logic [18:0] obs;
    logic [15:0] va [3] = '{16'h1234, 16'h8000, 16'h00FF};
    logic [15:0] vb [3] = '{16'h4321, 16'h8000, 16'h0F01};
    logic        vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [16:0] want [3] = '{17'h05555, 17'h10001, 17'h01000};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) step(1'b1, va[i], vb[i], vc[i], 1'b1, acc, fired, obs);
      else       step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, fired, obs);
      if (i < 3) begin
        tests_run++;
        if (acc !== 1'b1) begin
          tests_failed++;
          $display("FAIL stream_accept: beat %0d got accepted=%b, want 1", i, acc);
        end
      end
      if (i >= 2 && i <= 4) begin
        tests_run++;
        if ({fired, obs[16:0]} !== {1'b1, want[i-2]}) begin
          tests_failed++;
          $display("FAIL stream_result: beat %0d got valid=%b {cout,sum}=%h, want valid=1 %h",
                   i - 2, fired, obs[16:0], want[i-2]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc, fired;
    logic [18:0] obs, exp_v;
    logic [15:0] ba [4];
    logic [15:0] bb [4];
    logic        bc [4];
    int idx = 0;
    int got = 0;
    for (int i = 0; i < 4; i++) begin
      ba[i] = 16'($urandom); bb[i] = 16'($urandom); bc[i] = 1'($urandom);
    end
    for (int i = 0; i < 6; i++) begin
      step(idx < 4, ba[idx % 4], bb[idx % 4], bc[idx % 4], 1'b0, acc, fired, obs);
      if (acc) begin
        exp_q.push_back(model(ba[idx % 4], bb[idx % 4], bc[idx % 4]));
        idx++;
      end
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (idx !== 2 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_capacity: got accepted=%0d in_ready=%b, want accepted=2 in_ready=0", idx, in_ready);
    end
    tests_run++;
    if (exp_q.size() == 0 || {out_valid, gout, pout, cout, sum} !== {1'b1, exp_q[0]}) begin
      tests_failed++;
      $display("FAIL bp_hold: got valid=%b {g,p,cout,sum}=%h, want valid=1 %h",
               out_valid, {gout, pout, cout, sum}, model(ba[0], bb[0], bc[0]));
    end
    for (int i = 0; i < 30 && got < 4; i++) begin
      step(idx < 4, ba[idx % 4], bb[idx % 4], bc[idx % 4], 1'b1, acc, fired, obs);
      if (fired) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
        got++;
        tests_run++;
        if (obs !== exp_v) begin
          tests_failed++;
          $display("FAIL bp_drain: result %0d got %h, want %h", got - 1, obs, exp_v);
        end
      end
      if (acc) begin
        exp_q.push_back(model(ba[idx % 4], bb[idx % 4], bc[idx % 4]));
        idx++;
      end
    end
    tests_run++;
    if (got !== 4 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d results with %0d pending, want 4 with 0 pending", got, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    logic acc, fired, iv, ordy;
    logic [18:0] obs, exp_v;
    logic [15:0] ta, tb_v;
    logic tc;
    int n_in = 0;
    int n_out = 0;
    int bad = 0;
    for (int cyc = 0; cyc < 60000 && n_out < 10000; cyc++) begin
      iv   = (n_in < 10000) && ($urandom_range(3, 0) != 0);
      ordy = ($urandom_range(3, 0) != 0);
      ta = 16'($urandom); tb_v = 16'($urandom); tc = 1'($urandom);
      case ($urandom_range(7, 0))
        0: tb_v = ~ta;
        1: begin ta = 16'hFFFF; tb_v = 16'($urandom_range(1, 0)); end
        default: ;
      endcase
      step(iv, ta, tb_v, tc, ordy, acc, fired, obs);
      if (fired) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
        n_out++;
        tests_run++;
        if (obs !== exp_v) begin
          tests_failed++;
          bad++;
          if (bad <= 10)
            $display("FAIL random_beat: beat %0d got %h, want %h", n_out - 1, obs, exp_v);
        end
      end
      if (acc) begin
        exp_q.push_back(model(ta, tb_v, tc));
        n_in++;
      end
    end
    tests_run++;
    if (n_in !== 10000 || n_out !== n_in || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL random_count: got in=%0d out=%0d pending=%0d, want in=out=10000 pending=0",
               n_in, n_out, exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    test_reset();
    test_single("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000});
    test_single("prop_cin1",    16'hFFFF, 16'h0000, 1'b1, {1'b0, 1'b1, 1'b1, 16'h0000});
    test_single("prop_cin0",    16'hFFFF, 16'h0000, 1'b0, {1'b0, 1'b1, 1'b0, 16'hFFFF});
    test_back_to_back();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
